stall_data_mem: RTL and testbench
=================================

# stall_data_mem

Multi-cycle data memory responder serving the pipeline's memory stage. Accepts one read or write request at a time, holds the requester with `Stall` for a fixed configurable latency, then completes with a one-cycle `Done` pulse and returns read data. Replaces the single-cycle data memory behind the EX/MEM latch. The hazard logic freezes PC, IF/ID, ID/EX and EX/MEM while `Stall` is high.

## Interface
- `DEPTH_LOG2`, default 8: word-array depth is 2^DEPTH_LOG2 16-bit words.
- `LATENCY`, default 2: number of BUSY cycles per access. Legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `Addr` in 16: byte address. Word index is `Addr[DEPTH_LOG2:1]`.
- `DataIn` in 16: write data.
- `Rd` in 1: read request, level.
- `Wr` in 1: write request, level. Has priority when `Rd` is also high.
- `DataOut` out 16: read data, valid during `Done`, held until the next read completes.
- `Done` out 1: one-cycle completion pulse.
- `Stall` out 1: requester must hold `Addr`/`DataIn`/`Rd`/`Wr` and freeze upstream stages.
- `Busy` out 1: high in BUSY and DONE states (registered).
- `Err` out 1: alignment error pulse (see Configuration).

## Operation
- States: IDLE, BUSY, DONE. A 4-bit down-counter `cnt` tracks BUSY cycles.
- IDLE, with `Rd|Wr` high and the request legal:
  - Accept the request and latch op (write if `Wr`), word index and `DataIn`.
  - Load `cnt = LATENCY-1` and go to BUSY.
  - `Stall` is high combinationally in the accept cycle.
- IDLE, no request: stay in IDLE. `Stall=0`, `Done=0`.
- BUSY: inputs are ignored; the latched copies are used.
  - While `cnt!=0`: decrement `cnt`.
  - When `cnt==0`: go to DONE. On that edge, a write updates the array; a read loads the array word into `DataOut`.
- DONE: lasts one cycle. `Done=1`, `Stall=0`. Requests are ignored, because the requester's old request is still on the inputs in this cycle. Next state is IDLE.
- `Stall = (IDLE & (Rd|Wr) & legal) | BUSY`. This is the only combinational output. All others are registered.
- Read data reflects all writes completed earlier. A read never observes an in-flight write, since only one access is outstanding at a time.
- Reset values:
  - State IDLE, `cnt=0`.
  - `DataOut=0`, `Done=0`, `Busy=0`, `Err=0`, `Stall=0`.
  - Array contents are not reset.
- Reset mid-access: return to IDLE immediately. A pending write is dropped and the array is unchanged. No `Done` is produced.

## Timing
- Accept in cycle T. BUSY occupies T+1..T+LATENCY. `Done` and valid `DataOut` occur in T+LATENCY+1.
- `Stall` is high in cycles T..T+LATENCY, i.e. LATENCY+1 cycles.
- Earliest next accept is T+LATENCY+2. Back-to-back throughput is one access per LATENCY+2 cycles.
- LATENCY=1: accept at T, BUSY at T+1, `Done` at T+2.

## Configuration
- `STALL_MEM_ALIGN_CHECK_EN` defined:
  - A request in IDLE with `Addr[0]=1` is illegal.
  - It is not accepted, `Stall` stays 0, and the array is untouched.
  - `Err=1` for exactly one cycle, T+1, repeating every cycle while the illegal request persists in IDLE.
- Macro undefined: `Addr[0]` is ignored, all requests are legal, and `Err` is constant 0.

## Test plan
- Write then read, LATENCY=2:
  - Write `Addr=0x0010`, `DataIn=0xBEEF`: `Stall` high 3 cycles, then `Done` pulse with `Stall=0`.
  - Read `Addr=0x0010`: `DataOut=0xBEEF` in the `Done` cycle, held afterwards.
- Requester holds `Rd` through the `Done` cycle: no second access. The next accept occurs only in the following IDLE cycle. Verify exactly LATENCY+2 cycles per access.
- `Rd=1` and `Wr=1` at `Addr=0x0004`, `DataIn=0x1234`: treated as a write. A later read returns 0x1234.
- `rst` asserted during BUSY of a write of 0x5555 to `Addr=0x0020` (previously 0x0000):
  - Outputs go to 0 immediately.
  - A subsequent read of 0x0020 returns 0x0000.
- With `STALL_MEM_ALIGN_CHECK_EN`: read `Addr=0x0011` gives `Stall=0`, a one-cycle `Err` after one cycle, and no `Done`. Without the macro, the same read returns the word at 0x0010.
- LATENCY=1 and LATENCY=15 builds: `Done` at exactly T+2 and T+16 respectively.

Source files
------------

// File: rtl/stall_data_mem.sv
// Multi-cycle data memory responder: accepts one access, stalls the requester for LATENCY cycles, then pulses Done.
// Optional feature macro: STALL_MEM_ALIGN_CHECK_EN (reject odd byte addresses and pulse Err).
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for Rd/Wr; Stall raised combinationally on accept
// S_BUSY | access in flight, cnt counts down to the completion edge
// S_DONE | one-cycle completion, Done=1, incoming requests ignored
module stall_data_mem #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        Busy,
   output logic        Err
);

   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  op_wr_q, op_wr_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [15:0]           wdata_q, wdata_d;
   logic [15:0]           dout_q, dout_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  err_q, err_d;

   logic [15:0]           mem [DEPTH];

   logic                  req;
   logic                  legal;
   logic                  accept;
   logic                  finish;
   logic                  mem_we;
   logic                  unused_addr;

   assign req = Rd | Wr;

`ifdef STALL_MEM_ALIGN_CHECK_EN
   assign legal = ~Addr[0];
`else
   assign legal = 1'b1;
`endif

   // Byte-address bits outside the word index never reach the array.
   assign unused_addr = ^{Addr[15:DEPTH_LOG2+1], Addr[0]};

   assign accept = (state_q == S_IDLE) & req & legal;
   assign finish = (state_q == S_BUSY) & (cnt_q == 4'd0);
   assign mem_we = finish & op_wr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         op_wr_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 16'h0000;
         dout_q  <= 16'h0000;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   // Array has no reset; a write lands only on the completion edge, so a reset mid-access drops it.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[idx_q] <= wdata_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_BUSY;
               cnt_d   = CNT_LOAD;
               op_wr_d = Wr;
               idx_d   = Addr[DEPTH_LOG2:1];
               wdata_d = DataIn;
            end
         end
         S_BUSY: begin
            if (cnt_q == 4'd0) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_comb begin
      Stall  = accept | (state_q == S_BUSY);
      done_d = finish;
      busy_d = (state_d != S_IDLE);
      dout_d = dout_q;
      if (finish && !op_wr_q) begin
         dout_d = mem[idx_q];
      end
`ifdef STALL_MEM_ALIGN_CHECK_EN
      err_d = (state_q == S_IDLE) & req & ~legal;
`else
      err_d = 1'b0;
`endif
   end

   assign DataOut = dout_q;
   assign Done    = done_q;
   assign Busy    = busy_q;
   assign Err     = err_q;

endmodule

// File: tb/tb_stall_data_mem.sv
// Directed bench for stall_data_mem: table of accesses plus reset, hold-through-Done and alignment sequences.
module tb_stall_data_mem;

   parameter int LAT = 2;

   logic        clk;
   logic        rst;
   logic [15:0] Addr;
   logic [15:0] DataIn;
   logic        Rd;
   logic        Wr;
   logic [15:0] DataOut;
   logic        Done;
   logic        Stall;
   logic        Busy;
   logic        Err;

   int total;
   int bad;
   logic [15:0] last_rd;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] din;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[10];

   stall_data_mem #(
      .DEPTH_LOG2 (8),
      .LATENCY    (LAT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .Addr    (Addr),
      .DataIn  (DataIn),
      .Rd      (Rd),
      .Wr      (Wr),
      .DataOut (DataOut),
      .Done    (Done),
      .Stall   (Stall),
      .Busy    (Busy),
      .Err     (Err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Entered just after a rising edge with the DUT idle; returns just after the edge that ends the Done cycle.
   task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [15:0] din, input logic [15:0] exp, input bit hold);
      Rd = rd; Wr = wr; Addr = addr; DataIn = din;
      @(negedge clk);
      chk("accept_stall", {15'd0, Stall}, 16'd1);
      chk("accept_busy", {15'd0, Busy}, 16'd0);
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         chk("busy_stall", {15'd0, Stall}, 16'd1);
         chk("busy_done", {15'd0, Done}, 16'd0);
         chk("busy_busy", {15'd0, Busy}, 16'd1);
      end
      @(negedge clk);
      chk("done_pulse", {15'd0, Done}, 16'd1);
      chk("done_stall", {15'd0, Stall}, 16'd0);
      chk("done_busy", {15'd0, Busy}, 16'd1);
      chk("done_err", {15'd0, Err}, 16'd0);
      if (rd && !wr) last_rd = exp;
      chk("done_dout", DataOut, last_rd);
      @(posedge clk);
      #1;
      if (!hold) begin
         Rd = 1'b0; Wr = 1'b0;
      end
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      chk({tag, "_stall"}, {15'd0, Stall}, 16'd0);
      chk({tag, "_done"}, {15'd0, Done}, 16'd0);
      chk({tag, "_busy"}, {15'd0, Busy}, 16'd0);
      chk({tag, "_dout"}, DataOut, last_rd);
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0; bad = 0; last_rd = 16'h0000;
      rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000; DataIn = 16'h0000;

      vecs[0] = '{rd: 1'b0, wr: 1'b1, addr: 16'h0010, din: 16'hBEEF, exp: 16'h0000};
      vecs[1] = '{rd: 1'b1, wr: 1'b0, addr: 16'h0010, din: 16'h0000, exp: 16'hBEEF};
      vecs[2] = '{rd: 1'b1, wr: 1'b1, addr: 16'h0004, din: 16'h1234, exp: 16'h0000};
      vecs[3] = '{rd: 1'b1, wr: 1'b0, addr: 16'h0004, din: 16'hFFFF, exp: 16'h1234};
      vecs[4] = '{rd: 1'b0, wr: 1'b1, addr: 16'h0020, din: 16'h0000, exp: 16'h0000};
      vecs[5] = '{rd: 1'b0, wr: 1'b1, addr: 16'h01FE, din: 16'hA5A5, exp: 16'h0000};
      vecs[6] = '{rd: 1'b1, wr: 1'b0, addr: 16'h01FE, din: 16'h0000, exp: 16'hA5A5};
      vecs[7] = '{rd: 1'b1, wr: 1'b0, addr: 16'h0210, din: 16'h0000, exp: 16'hBEEF};
      vecs[8] = '{rd: 1'b1, wr: 1'b0, addr: 16'h0020, din: 16'h0000, exp: 16'h0000};
      vecs[9] = '{rd: 1'b1, wr: 1'b0, addr: 16'h0004, din: 16'h0000, exp: 16'h1234};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", {15'd0, Stall}, 16'd0);
      chk("rst_done", {15'd0, Done}, 16'd0);
      chk("rst_busy", {15'd0, Busy}, 16'd0);
      chk("rst_err", {15'd0, Err}, 16'd0);
      chk("rst_dout", DataOut, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_check("idle0");

      for (int i = 0; i < 10; i++) begin
         do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].exp, 1'b0);
         idle_check("after_vec");
      end

      // Rd held through Done: the second accept lands exactly LAT+2 cycles after the first.
      do_access(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1);
      do_access(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
      idle_check("hold_end");

      // Reset during BUSY of a write: the write is dropped.
      Wr = 1'b1; Addr = 16'h0020; DataIn = 16'h5555;
      @(negedge clk);
      chk("rstmid_accept", {15'd0, Stall}, 16'd1);
      @(posedge clk);
      #1;
      rst = 1'b1; Wr = 1'b0;
      #1;
      chk("rstmid_stall", {15'd0, Stall}, 16'd0);
      chk("rstmid_busy", {15'd0, Busy}, 16'd0);
      chk("rstmid_done", {15'd0, Done}, 16'd0);
      last_rd = 16'h0000;
      chk("rstmid_dout", DataOut, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle_check("post_rst");
      do_access(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0);
      idle_check("post_rst_rd");
      do_access(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);

      // Odd byte address.
`ifdef STALL_MEM_ALIGN_CHECK_EN
      Rd = 1'b1; Addr = 16'h0011;
      @(negedge clk);
      chk("align_stall", {15'd0, Stall}, 16'd0);
      chk("align_err_t", {15'd0, Err}, 16'd0);
      @(posedge clk);
      #1;
      Rd = 1'b0;
      @(negedge clk);
      chk("align_err_t1", {15'd0, Err}, 16'd1);
      chk("align_busy", {15'd0, Busy}, 16'd0);
      for (int k = 0; k < LAT + 2; k++) begin
         @(negedge clk);
         chk("align_err_off", {15'd0, Err}, 16'd0);
         chk("align_no_done", {15'd0, Done}, 16'd0);
      end
      chk("align_dout", DataOut, last_rd);
      @(posedge clk);
      #1;
`else
      do_access(1'b1, 1'b0, 16'h0011, 16'h0000, 16'hBEEF, 1'b0);
      idle_check("odd_rd");
      chk("odd_err", {15'd0, Err}, 16'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
